ring_input: RTL
===============

Name: ring_input

Overview:
- Input-channel buffer for one ring direction (instantiated once for cw, once for ccw) in the Cardinal router.
- Accepts 64-bit packets from the neighbouring router's link and holds them in two single-entry virtual-channel buffers, even and odd.
- Decodes the hop field to steer each packet either to the local PE output stage (pe_output) or to this router's forwarding ring output stage.
- Releases each buffer on the consumer's grant.

Parameters:
DATA_WIDTH, 64, packet width; only 64 is supported.
HOP_MSB, 55, MSB of the hop field.
HOP_LSB, 48, LSB of the hop field.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
polarity  input  1  global VC phase; 0 = link writes even buffer, 1 = link writes odd buffer.
si  input  1  link send-in; packet valid on di.
ri  output  1  ready-out to the upstream link.
di  input  64  packet from the upstream link.
request_pe_even  output  1  even buffer holds a packet for the local PE.
request_pe_odd  output  1  odd buffer holds a packet for the local PE.
request_fwd_even  output  1  even buffer holds a packet to forward on the ring.
request_fwd_odd  output  1  odd buffer holds a packet to forward on the ring.
grant_pe_even, grant_pe_odd, grant_fwd_even, grant_fwd_odd  input  1 each  consumer grants.
data_out_even  output  64  even buffer contents.
data_out_odd  output  64  odd buffer contents.

Behaviour:
- Reset (async, rst=1):
  - full_even = full_odd = 0; data_out_even = data_out_odd = 0.
  - All requests = 0; grant edge-detect registers = 0.
  - ri = 1, since it is combinational and the target buffer is empty.
- ri = polarity ? ~full_odd : ~full_even. This is combinational; no other term affects it.
- Write: on posedge with si & ri, the target buffer (per polarity) loads di and sets full.
  - si while ri=0 is ignored: no load, no error, and the buffer keeps its old contents.
- Hop rule, applied at write time:
  - hop = di[55:48].
  - If hop == 0: the packet is for the PE. It is stored unchanged and its route bit = PE.
  - Else: route bit = FWD and the stored hop field = hop >> 1; all other bits are unchanged.
- Requests are registered outputs: request_pe_x = full_x & route_x==PE; request_fwd_x = full_x & route_x==FWD.
  - Asserted the cycle after the write edge.
  - Held until consumed.
- Consume:
  - grant_x = grant_pe_x | grant_fwd_x matching the buffer's route bit. A grant of the wrong route is ignored.
  - The buffer is consumed only on a grant rising edge (grant_x=1 while the registered grant_x_d=0).
  - On that posedge, full_x is cleared and requests drop the same edge.
  - A grant held high for several cycles consumes exactly one packet.
  - data_out_x keeps its last value after consume; consumers must qualify it with the request.
- Per-buffer state machine with states EMPTY and FULL_PE / FULL_FWD:
  - EMPTY -> FULL_*: on write.
  - FULL_* -> EMPTY: on consume edge.
  - Write and consume on the same buffer in the same cycle cannot occur when polarity-correct, but if they do, the write wins: the buffer is reloaded and full stays 1.
- Latency:
  - di to request: 1 cycle.
  - Grant rising edge to request low and ri high (in that buffer's phase): 1 cycle.
- Even and odd buffers are fully independent; both may be full and requesting simultaneously.
- Reset asserted mid-operation discards buffered packets immediately. Requests drop without waiting for a clock edge.

Test Plan:
- Reset, then polarity=0, si=1, di=64'h0000_0000_0000_00AA (hop=0) -> next cycle request_pe_even=1, data_out_even=64'h..AA, ri=0 while polarity=0; odd outputs stay 0.
- polarity=1, di=64'h8004_0000_0000_0011 (hop=8'h04) -> request_fwd_odd=1, data_out_odd=64'h8002_0000_0000_0011.
- Full even buffer, hold grant_pe_even=1 for 3 cycles while new packets arrive in later polarity=0 phases -> exactly one packet consumed per rising edge; the second packet is retained, with request_pe_even=1 again after reload.
- Both buffers full (even PE, odd FWD); pulse grant_fwd_even -> ignored (wrong route); pulse grant_pe_even -> only the even buffer empties, odd unaffected.
- si=1 with target buffer full -> ri=0, contents unchanged for 5 cycles; then grant -> ri=1 and the next packet is accepted.
- Assert rst asynchronously mid-cycle with both buffers full -> all requests and data_out go to 0 immediately and ri=1; normal operation resumes after rst deasserts.

Source files
------------

// File: rtl/ring_input_if.sv
// Link and consumer-side signal bundle for one ring input channel.
interface ring_input_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  polarity;
  logic                  si;
  logic                  ri;
  logic [DATA_WIDTH-1:0] di;
  logic                  request_pe_even;
  logic                  request_pe_odd;
  logic                  request_fwd_even;
  logic                  request_fwd_odd;
  logic                  grant_pe_even;
  logic                  grant_pe_odd;
  logic                  grant_fwd_even;
  logic                  grant_fwd_odd;
  logic [DATA_WIDTH-1:0] data_out_even;
  logic [DATA_WIDTH-1:0] data_out_odd;

  // The input buffer itself.
  modport slave (
    input  polarity, si, di,
    input  grant_pe_even, grant_pe_odd, grant_fwd_even, grant_fwd_odd,
    output ri,
    output request_pe_even, request_pe_odd, request_fwd_even, request_fwd_odd,
    output data_out_even, data_out_odd
  );

  // Upstream link plus the PE / forwarding consumers.
  modport master (
    output polarity, si, di,
    output grant_pe_even, grant_pe_odd, grant_fwd_even, grant_fwd_odd,
    input  ri,
    input  request_pe_even, request_pe_odd, request_fwd_even, request_fwd_odd,
    input  data_out_even, data_out_odd
  );
endinterface

// File: rtl/ring_input.sv
// Ring input channel: two single-entry VC buffers (even/odd) selected by the
// global polarity. Each packet is tagged at write time as PE-bound (hop == 0)
// or forward-bound (hop decremented by a right shift) and released on the
// rising edge of the matching consumer grant.
//
// state    | meaning
// ---------+----------------------------------------------
// EMPTY    | buffer free, link may write it in its phase
// FULL_PE  | holds a packet for the local PE
// FULL_FWD | holds a packet to forward on the ring
module ring_input #(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic             clk,
  input  logic             rst,
  ring_input_if.slave      link
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL_PE  = 2'd1,
    FULL_FWD = 2'd2
  } buf_state_e;

  // Index 0 = even buffer, index 1 = odd buffer.
  buf_state_e            state_q [2];
  buf_state_e            state_d [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [1:0]            route_q, route_d;           // 1 = FWD, 0 = PE
  logic [1:0]            grant_prev_q, grant_prev_d;
  logic [1:0]            req_pe_q, req_pe_d;
  logic [1:0]            req_fwd_q, req_fwd_d;

  logic [1:0]            full;
  logic [1:0]            wr;
  logic [1:0]            grant_now;
  logic [1:0]            consume;
  logic [1:0]            grant_pe;
  logic [1:0]            grant_fwd;
  logic                  ri;
  logic [HOP_W-1:0]      hop;
  logic                  hop_zero;
  logic [DATA_WIDTH-1:0] wr_data;

  assign grant_pe  = {link.grant_pe_odd,  link.grant_pe_even};
  assign grant_fwd = {link.grant_fwd_odd, link.grant_fwd_even};

  // Next-state logic: hop rewrite, write/consume decode, request derivation.
  always_comb begin
    hop      = link.di[HOP_MSB:HOP_LSB];
    hop_zero = (hop == '0);
    wr_data  = link.di;
    if (!hop_zero) begin
      wr_data[HOP_MSB:HOP_LSB] = hop >> 1;
    end

    full[0] = (state_q[0] != EMPTY);
    full[1] = (state_q[1] != EMPTY);
    ri      = link.polarity ? ~full[1] : ~full[0];

    for (int i = 0; i < 2; i++) begin
      // Only the grant matching the stored route can release the buffer.
      grant_now[i]    = route_q[i] ? grant_fwd[i] : grant_pe[i];
      consume[i]      = full[i] & grant_now[i] & ~grant_prev_q[i];
      wr[i]           = link.si & ri & (link.polarity == 1'(i));

      state_d[i]      = state_q[i];
      data_d[i]       = data_q[i];
      route_d[i]      = route_q[i];
      grant_prev_d[i] = grant_now[i];

      if (consume[i]) begin
        state_d[i] = EMPTY;
      end
      // A write in the same cycle as a consume takes precedence.
      if (wr[i]) begin
        state_d[i] = hop_zero ? FULL_PE : FULL_FWD;
        data_d[i]  = wr_data;
        route_d[i] = ~hop_zero;
      end

      req_pe_d[i]  = (state_d[i] == FULL_PE);
      req_fwd_d[i] = (state_d[i] == FULL_FWD);
    end
  end

  // Buffer state, contents, grant history and registered requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
      route_q      <= '0;
      grant_prev_q <= '0;
      req_pe_q     <= '0;
      req_fwd_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      route_q      <= route_d;
      grant_prev_q <= grant_prev_d;
      req_pe_q     <= req_pe_d;
      req_fwd_q    <= req_fwd_d;
    end
  end

  assign link.ri               = ri;
  assign link.request_pe_even  = req_pe_q[0];
  assign link.request_pe_odd   = req_pe_q[1];
  assign link.request_fwd_even = req_fwd_q[0];
  assign link.request_fwd_odd  = req_fwd_q[1];
  assign link.data_out_even    = data_q[0];
  assign link.data_out_odd     = data_q[1];

endmodule
